// File: rtl/vga_bounce_pixel_gen_pkg.sv
// Shared constants for the bouncing-square pixel generator: frame timing, window size,
// direction-state encoding and RGB values.
package vga_bounce_pixel_gen_pkg;

    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 521;
    localparam int WIN_SIZE = 256;

    // Per-axis direction bit: 0 = moving toward +coord (right/down), 1 = toward -coord
    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    // {dx,dy} direction states
    localparam logic [1:0] DIR_DOWN_RIGHT = {DIR_POS, DIR_POS};

    localparam logic [2:0] RGB_BLACK = 3'b000;
    localparam logic [2:0] RGB_BLUE  = 3'b001;
`ifdef VGA_PIXGEN_GRID_EN
    localparam logic [2:0] RGB_WHITE = 3'b111;
`endif

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing square: next position and direction for a single update step,
// reflecting off the 0 and MAX walls without 8-bit wrap.
module vga_bounce_axis
    import vga_bounce_pixel_gen_pkg::*;
#(
    parameter int STEP = 1,
    parameter int MAX  = 240
) (
    input  logic [7:0] pos,
    input  logic       dir,
    output logic [7:0] next_pos,
    output logic       next_dir
);

    logic [8:0] sum;

    always_comb begin
        sum      = {1'b0, pos} + 9'(STEP);
        next_pos = pos;
        next_dir = dir;
        if (dir == DIR_POS) begin
            if (sum > 9'(MAX)) begin
                next_pos = 8'(9'(2 * MAX) - sum);
                next_dir = DIR_NEG;
            end else begin
                next_pos = sum[7:0];
            end
        end else begin
            if (pos < 8'(STEP)) begin
                next_pos = 8'(STEP) - pos;
                next_dir = DIR_POS;
            end else begin
                next_pos = pos - 8'(STEP);
            end
        end
    end

endmodule

// File: rtl/vga_bounce_pixel_gen.sv
// Pixel source for the VGA controller: checkerboard window with a square bouncing once per
// FRAME_DIV frames. Define VGA_PIXGEN_GRID_EN to overlay a white 32-pixel grid on the background.
//
// state          | meaning ({dx,dy})
// DOWN_RIGHT  00 | x increasing, y increasing (reset state)
// DOWN_LEFT   10 | x decreasing, y increasing
// UP_RIGHT    01 | x increasing, y decreasing
// UP_LEFT     11 | x decreasing, y decreasing
module vga_bounce_pixel_gen
    import vga_bounce_pixel_gen_pkg::*;
#(
    parameter int WIN_X0    = 242,
    parameter int WIN_Y0    = 142,
    parameter int SQ_SIZE   = 16,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [9:0] iHcounter,
    input  logic [9:0] iVcounter,
    input  logic       iPause,
    input  logic [2:0] iColor,
    output logic [2:0] oVGA_RGB,
    output logic [7:0] oXRedCounter,
    output logic [7:0] oYRedCounter,
    output logic [2:0] oColorCuadro,
    output logic       oFrameTick
);

    localparam int MAX = WIN_SIZE - SQ_SIZE;

    logic [7:0] div_cnt;
    logic [1:0] dir_state;
    logic       frame_end;
    logic       update;
    logic [7:0] next_x;
    logic [7:0] next_y;
    logic       next_dx;
    logic       next_dy;

    assign frame_end = (iHcounter == 10'(H_TOTAL - 1)) && (iVcounter == 10'(V_TOTAL - 1));
    assign update    = frame_end && (div_cnt == 8'(FRAME_DIV - 1));

    vga_bounce_axis #(.STEP(STEP), .MAX(MAX)) u_axis_x (
        .pos      (oXRedCounter),
        .dir      (dir_state[1]),
        .next_pos (next_x),
        .next_dir (next_dx)
    );

    vga_bounce_axis #(.STEP(STEP), .MAX(MAX)) u_axis_y (
        .pos      (oYRedCounter),
        .dir      (dir_state[0]),
        .next_pos (next_y),
        .next_dir (next_dy)
    );

    // Position moves only on the frame-end edge, so every visible pixel of a frame sees one position
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oFrameTick   <= 1'b0;
            div_cnt      <= '0;
            dir_state    <= DIR_DOWN_RIGHT;
            oXRedCounter <= '0;
            oYRedCounter <= '0;
            oColorCuadro <= '0;
        end else begin
            oFrameTick   <= frame_end;
            oColorCuadro <= iColor;
            if (frame_end) begin
                div_cnt <= update ? '0 : div_cnt + 8'd1;
            end
            if (update && !iPause) begin
                oXRedCounter <= next_x;
                oYRedCounter <= next_y;
                dir_state    <= {next_dx, next_dy};
            end
        end
    end

    logic       in_win;
    logic [7:0] lx;
    logic [7:0] ly;
    logic [7:0] dx_sq;
    logic [7:0] dy_sq;
    logic [2:0] pixel;

    assign in_win = (iHcounter >= 10'(WIN_X0)) && (iHcounter < 10'(WIN_X0 + WIN_SIZE)) &&
                    (iVcounter >= 10'(WIN_Y0)) && (iVcounter < 10'(WIN_Y0 + WIN_SIZE));
    assign lx     = 8'(iHcounter - 10'(WIN_X0));
    assign ly     = 8'(iVcounter - 10'(WIN_Y0));
    assign dx_sq  = lx - oXRedCounter;
    assign dy_sq  = ly - oYRedCounter;

    always_comb begin
        pixel = RGB_BLACK;
        if (in_win) begin
            if (dx_sq < 8'(SQ_SIZE) && dy_sq < 8'(SQ_SIZE)) begin
                pixel = iColor;
`ifdef VGA_PIXGEN_GRID_EN
            end else if (lx[4:0] == 5'd0 || ly[4:0] == 5'd0) begin
                pixel = RGB_WHITE;
`endif
            end else begin
                pixel = (lx[4] ^ ly[4]) ? RGB_BLUE : RGB_BLACK;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oVGA_RGB <= RGB_BLACK;
        end else begin
            oVGA_RGB <= pixel;
        end
    end

endmodule
